fifo_sync_param: RTL and testbench



---
 rtl/fifo_sync_param_pkg.sv | 20 ++
 rtl/fifo_sync_param_if.sv | 53 +++++
 rtl/fifo_mem_rf.sv | 26 ++
 rtl/fifo_sync_param.sv | 127 ++++++++++++
 tb/tb_fifo_sync_param.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_sync_param_pkg.sv
// Shared definitions for the synchronous FIFO family: default geometry,
// almost-flag thresholds and read-mode encodings.
package fifo_sync_param_pkg;

  // Default geometry and thresholds
  localparam int FIFO_DATA_W_DEF = 32;
  localparam int FIFO_ADDR_W_DEF = 4;
  localparam int FIFO_AF_LVL_DEF = 14;
  localparam int FIFO_AE_LVL_DEF = 2;

  // Read-mode encodings for the FWFT parameter
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Number of words addressed by an addr_w-bit pointer
  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Data/handshake/status bundle between a FIFO and its user.
// With FIFO_ERR_FLAG_EN defined it also carries err_clr, overflow, underflow.
interface fifo_sync_param_if
  import fifo_sync_param_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W_DEF,
  parameter int ADDR_W = FIFO_ADDR_W_DEF
);

  logic [DATA_W-1:0] data_in;
  logic              en_write;
  logic              en_read;
  logic [DATA_W-1:0] data_out;
  logic              fifo_full;
  logic              fifo_empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
`ifdef FIFO_ERR_FLAG_EN
  logic              err_clr;
  logic              overflow;
  logic              underflow;
`endif

`ifdef FIFO_ERR_FLAG_EN
  // User side: drives requests and write data, observes status
  modport master (
    output data_in, en_write, en_read, err_clr,
    input  data_out, fifo_full, fifo_empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  // FIFO side
  modport slave (
    input  data_in, en_write, en_read, err_clr,
    output data_out, fifo_full, fifo_empty, almost_full, almost_empty, count,
           overflow, underflow
  );
`else
  // User side: drives requests and write data, observes status
  modport master (
    output data_in, en_write, en_read,
    input  data_out, fifo_full, fifo_empty, almost_full, almost_empty, count
  );

  // FIFO side
  modport slave (
    input  data_in, en_write, en_read,
    output data_out, fifo_full, fifo_empty, almost_full, almost_empty, count
  );
`endif

endinterface

// File: rtl/fifo_mem_rf.sv
// DEPTH x DATA_W register-file storage: synchronous write, asynchronous read.
// Kept free of FIFO control so dual-clock variants can reuse it.
module fifo_mem_rf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port: store one word per enabled edge
  // NOTE: storage has no reset; the pointers decide which words are valid,
  // and a reset on the array would block mapping to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with fill count, programmable almost flags
// and standard (registered) or first-word-fall-through read mode.
// Optional feature macro: FIFO_ERR_FLAG_EN (sticky overflow/underflow flags).
module fifo_sync_param
  import fifo_sync_param_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W_DEF,
  parameter int ADDR_W = FIFO_ADDR_W_DEF,
  parameter int AF_LVL = FIFO_AF_LVL_DEF,
  parameter int AE_LVL = FIFO_AE_LVL_DEF,
  parameter int FWFT   = FIFO_MODE_STD
) (
  input  logic               clk,
  input  logic               rst,
  fifo_sync_param_if.slave   bus
);

  localparam int                DEPTH   = fifo_depth(ADDR_W);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AF_C    = (ADDR_W+1)'(AF_LVL);
  localparam logic [ADDR_W:0]   AE_C    = (ADDR_W+1)'(AE_LVL);
  localparam logic [ADDR_W-1:0] PTR_INC = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_INC = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic [DATA_W-1:0] rd_word;
  logic              wr_acc;
  logic              rd_acc;
  logic              empty_w;
  logic              full_w;

  // Status flags decoded from the registered count
  assign empty_w          = (count_q == '0);
  assign full_w           = (count_q == DEPTH_C);
  assign bus.fifo_empty   = empty_w;
  assign bus.fifo_full    = full_w;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;

  // Request acceptance: a write into a full FIFO is allowed when a pop frees a slot
  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch can be inferred.
  always_comb begin
    rd_acc = 1'b0;
    wr_acc = 1'b0;
    rd_acc = bus.en_read & ~empty_w;
    wr_acc = bus.en_write & (~full_w | rd_acc);
  end

  // Pointers and occupancy
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_INC;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_INC;
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CNT_INC;
        2'b01:   count_q <= count_q - CNT_INC;
        default: count_q <= count_q;
      endcase
    end
  end

  fifo_mem_rf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (bus.data_in),
    .rd_addr (rd_ptr),
    .rd_data (rd_word)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word is shown as soon as it exists; zero while empty
      assign bus.data_out = empty_w ? '0 : rd_word;
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;

      // Registered read: popped word appears one edge after the request
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         dout_q <= '0;
        else if (rd_acc) dout_q <= rd_word;
      end

      assign bus.data_out = dout_q;
    end
  endgenerate

`ifdef FIFO_ERR_FLAG_EN
  logic overflow_q;
  logic underflow_q;
  logic ovf_set;
  logic udf_set;

  assign ovf_set = bus.en_write & full_w & ~rd_acc;
  assign udf_set = bus.en_read & empty_w;

  // Sticky error flags; a new event in the clearing cycle keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (ovf_set)          overflow_q  <= 1'b1;
      else if (bus.err_clr) overflow_q  <= 1'b0;
      if (udf_set)          underflow_q <= 1'b1;
      else if (bus.err_clr) underflow_q <= 1'b0;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: a standard-mode instance driven by
// directed vectors with a queue model, plus an FWFT instance for fall-through.
module tb_fifo_sync_param;
  import fifo_sync_param_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_sync_param_if #(.DATA_W(DW), .ADDR_W(AW)) s_if ();
  fifo_sync_param_if #(.DATA_W(DW), .ADDR_W(AW)) f_if ();

  fifo_sync_param #(
    .DATA_W(DW), .ADDR_W(AW), .AF_LVL(14), .AE_LVL(2), .FWFT(FIFO_MODE_STD)
  ) u_std (
    .clk (clk),
    .rst (rst),
    .bus (s_if.slave)
  );

  fifo_sync_param #(
    .DATA_W(DW), .ADDR_W(AW), .AF_LVL(14), .AE_LVL(2), .FWFT(FIFO_MODE_FWFT)
  ) u_fwft (
    .clk (clk),
    .rst (rst),
    .bus (f_if.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mq    [$];   // model of stored words (standard instance)
  logic [DW-1:0] exp_q [$];   // expected read data, one per accepted pop

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each accepted pop produces one data_out word after its edge
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rd_data", s_if.data_out, e);
      end
    end
  end

  // One clock of stimulus on the standard instance, then status vs model
  task automatic step(input bit wr, input int d, input bit rd);
    bit racc;
    bit wacc;
    int n;
    racc = rd && (mq.size() > 0);
    wacc = wr && ((mq.size() < 16) || racc);
    s_if.en_write = wr;
    s_if.data_in  = d;
    s_if.en_read  = rd;
    @(posedge clk);
    if (racc) exp_q.push_back(mq.pop_front());
    if (wacc) mq.push_back(d);
    @(negedge clk);
    n = mq.size();
    check("count",        64'(s_if.count),        64'(n));
    check("fifo_empty",   64'(s_if.fifo_empty),   64'(n == 0));
    check("fifo_full",    64'(s_if.fifo_full),    64'(n == 16));
    check("almost_full",  64'(s_if.almost_full),  64'(n >= 14));
    check("almost_empty", 64'(s_if.almost_empty), 64'(n <= 2));
    s_if.en_write = 1'b0;
    s_if.en_read  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_count"},   64'(s_if.count),        64'd0);
    check({tag, "_empty"},   64'(s_if.fifo_empty),   64'd1);
    check({tag, "_full"},    64'(s_if.fifo_full),    64'd0);
    check({tag, "_ae"},      64'(s_if.almost_empty), 64'd1);
    check({tag, "_af"},      64'(s_if.almost_full),  64'd0);
    check({tag, "_dout"},    64'(s_if.data_out),     64'd0);
    check({tag, "_f_dout"},  64'(f_if.data_out),     64'd0);
    check({tag, "_f_empty"}, 64'(f_if.fifo_empty),   64'd1);
  endtask

  // Reset pulse placed mid-low-phase, checked before any clock edge
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_reset_vals(tag);
    rst = 1'b0;
    mq.delete();
    exp_q.delete();
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    s_if.en_write = 1'b0; s_if.en_read = 1'b0; s_if.data_in = '0;
    f_if.en_write = 1'b0; f_if.en_read = 1'b0; f_if.data_in = '0;
`ifdef FIFO_ERR_FLAG_EN
    s_if.err_clr = 1'b0;
    f_if.err_clr = 1'b0;
`endif

    // 1. Reset between edges, then again with 5 words stored
    #2 rst = 1'b1;
    #1 check_reset_vals("rst0");
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 5; i++) step(1, i, 0);
    check("count_5", 64'(s_if.count), 64'd5);
    pulse_reset("rst5");
    @(negedge clk);

    // 2. Fill 1..16, then an extra write is dropped
    for (int i = 1; i <= 16; i++) begin
      step(1, i, 0);
      if (i == 13) check("af_before_14", 64'(s_if.almost_full), 64'd0);
      if (i == 14) check("af_at_14",     64'(s_if.almost_full), 64'd1);
    end
    check("full_16", 64'(s_if.fifo_full), 64'd1);
    step(1, 99, 0);
    check("count_drop", 64'(s_if.count), 64'd16);
`ifdef FIFO_ERR_FLAG_EN
    check("overflow_set", 64'(s_if.overflow), 64'd1);
`endif

    // 3. Drain: monitor expects 1..16; an extra read holds data_out
    for (int i = 1; i <= 16; i++) step(0, 0, 1);
    check("dout_last", 64'(s_if.data_out), 64'd16);
    step(0, 0, 1);
    check("dout_hold", 64'(s_if.data_out), 64'd16);
`ifdef FIFO_ERR_FLAG_EN
    check("underflow_set", 64'(s_if.underflow), 64'd1);
    check("overflow_sticky", 64'(s_if.overflow), 64'd1);
    s_if.err_clr = 1'b1;
    step(0, 0, 0);
    s_if.err_clr = 1'b0;
    check("underflow_clr", 64'(s_if.underflow), 64'd0);
    check("overflow_clr",  64'(s_if.overflow),  64'd0);
`endif

    // 4. Simultaneous access at full and at empty
    for (int i = 1; i <= 16; i++) step(1, i, 0);
    step(1, 100, 1);
    check("full_wr_rd_count", 64'(s_if.count), 64'd16);
    for (int i = 1; i <= 16; i++) step(0, 0, 1);
    check("dout_100_last", 64'(s_if.data_out), 64'd100);
    step(1, 7, 1);
    check("empty_wr_rd_count", 64'(s_if.count), 64'd1);
    check("empty_wr_rd_dout",  64'(s_if.data_out), 64'd100);
    step(0, 0, 1);

    // 5. Wrap-around from pointer 0
    pulse_reset("rst_wrap");
    @(negedge clk);
    for (int i = 1; i <= 10; i++) step(1, i, 0);
    for (int i = 1; i <= 10; i++) step(0, 0, 1);
    for (int i = 21; i <= 30; i++) step(1, i, 0);
    for (int i = 1; i <= 10; i++) step(0, 0, 1);
    check("wrap_count", 64'(s_if.count), 64'd0);
    check("wrap_dout",  64'(s_if.data_out), 64'd30);

    // 6. First-word-fall-through instance
    check("fwft_idle_dout", 64'(f_if.data_out), 64'd0);
    f_if.data_in  = 32'd5;
    f_if.en_write = 1'b1;
    @(posedge clk);
    #1 f_if.en_write = 1'b0;
    check("fwft_dout_5",  64'(f_if.data_out),   64'd5);
    check("fwft_not_emp", 64'(f_if.fifo_empty), 64'd0);
    check("fwft_count_1", 64'(f_if.count),      64'd1);
    f_if.en_read = 1'b1;
    @(posedge clk);
    #1 f_if.en_read = 1'b0;
    check("fwft_dout_0",  64'(f_if.data_out),   64'd0);
    check("fwft_empty",   64'(f_if.fifo_empty), 64'd1);

    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
